matrix_add_driver: RTL and testbench

- Host-side front end for the matrix_addition engine; drives that engine's start/done handshake.
- Accepts a byte stream on a valid/ready input and unpacks it into the 4x4 A and B operand arrays.
- Pulses start, waits for completion, snapshots the 16-bit result matrix, and streams it out on a valid/ready output.

---
 rtl/matrix_add_driver_if.sv | 23 ++
 rtl/matrix_add_driver.sv | 121 ++++++++++++
 tb/tb_matrix_add_driver.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_add_driver_if.sv
// Host-side stream bundle for matrix_add_driver: operand bytes in, result words out.
interface matrix_add_driver_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matrix_add_driver.sv
// Front end for the matrix_addition engine: unpacks a byte stream into A/B,
// runs one start/done handshake, then streams the snapshotted result row-major.
module matrix_add_driver #(
  parameter int DIM       = 4,
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16,
  parameter int DONE_WAIT = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  matrix_add_driver_if.slave                io,
  output logic [DIM-1:0][DIM-1:0][IN_W-1:0] mat_a,
  output logic [DIM-1:0][DIM-1:0][IN_W-1:0] mat_b,
  output logic                              add_start,
  input  logic                              add_done,
  input  logic [DIM-1:0][DIM-1:0][OUT_W-1:0] mat_c,
  output logic                              busy
);
  localparam int N      = DIM * DIM;
  localparam int IDX_W  = $clog2(N);
  localparam int K_W    = IDX_W + 1;
  localparam int WAIT_W = $clog2(DONE_WAIT);

  localparam logic [K_W-1:0]    K_LAST = K_W'(2 * N - 1);
  localparam logic [IDX_W-1:0]  M_LAST = IDX_W'(N - 1);
  localparam logic [WAIT_W-1:0] W_LAST = WAIT_W'(DONE_WAIT - 1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]              state;
  logic [K_W-1:0]          k;
  logic [IDX_W-1:0]        m;
  logic [IDX_W-1:0]        m_next;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    done_was_high;
  logic                    complete;
  logic [N-1:0][IN_W-1:0]  a_flat;
  logic [N-1:0][IN_W-1:0]  b_flat;
  logic [N-1:0][OUT_W-1:0] c_flat;
  logic [N-1:0][OUT_W-1:0] res_buf;

  // Flat row-major views line up bit-for-bit with the [row][col] packed ports.
  assign mat_a  = a_flat;
  assign mat_b  = b_flat;
  assign c_flat = mat_c;

  assign io.in_ready = (state == S_LOAD) && !rst;
  assign add_start   = (state == S_START);
  assign busy        = (state != S_LOAD);
  assign m_next      = m + IDX_W'(1);

  // A done that was already high at start is stale, so fall back to a fixed wait.
  assign complete = done_was_high ? (wait_cnt == W_LAST) : add_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_LOAD;
      k             <= '0;
      m             <= '0;
      wait_cnt      <= '0;
      done_was_high <= 1'b0;
      a_flat        <= '0;
      b_flat        <= '0;
      res_buf       <= '0;
      io.out_valid  <= 1'b0;
      io.out_data   <= '0;
      io.out_last   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (io.in_valid) begin
            if (!k[K_W-1]) a_flat[k[IDX_W-1:0]] <= io.in_data;
            else           b_flat[k[IDX_W-1:0]] <= io.in_data;
            if (k == K_LAST) begin
              k     <= '0;
              state <= S_START;
            end else begin
              k <= k + K_W'(1);
            end
          end
        end
        S_START: begin
          done_was_high <= add_done;
          wait_cnt      <= '0;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (complete) begin
            res_buf      <= c_flat;
            wait_cnt     <= '0;
            m            <= '0;
            io.out_valid <= 1'b1;
            io.out_data  <= c_flat[0];
            io.out_last  <= 1'b0;
            state        <= S_DRAIN;
          end else if (done_was_high) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          if (io.out_ready) begin
            if (m == M_LAST) begin
              m            <= '0;
              io.out_valid <= 1'b0;
              io.out_data  <= '0;
              io.out_last  <= 1'b0;
              state        <= S_LOAD;
            end else begin
              m           <= m_next;
              io.out_data <= res_buf[m_next];
              io.out_last <= (m_next == M_LAST);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_add_driver.sv
// Directed bench for matrix_add_driver with a behavioural 22-cycle sticky-done adder.
module tb_matrix_add_driver;
  localparam int DIM       = 4;
  localparam int IN_W      = 8;
  localparam int OUT_W     = 16;
  localparam int DONE_WAIT = 24;
  localparam int N         = DIM * DIM;
  localparam int ADD_LAT   = 22;

  logic clk;
  logic rst;
  logic adder_rst;
  logic [DIM-1:0][DIM-1:0][IN_W-1:0]  mat_a;
  logic [DIM-1:0][DIM-1:0][IN_W-1:0]  mat_b;
  logic                               add_start;
  logic                               add_done;
  logic [DIM-1:0][DIM-1:0][OUT_W-1:0] mat_c;
  logic                               busy;

  matrix_add_driver_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  matrix_add_driver #(
    .DIM(DIM), .IN_W(IN_W), .OUT_W(OUT_W), .DONE_WAIT(DONE_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(bus),
    .mat_a(mat_a),
    .mat_b(mat_b),
    .add_start(add_start),
    .add_done(add_done),
    .mat_c(mat_c),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: captures operands on start, publishes sums and a sticky done 22 edges later.
  logic [DIM-1:0][DIM-1:0][IN_W-1:0] op_a;
  logic [DIM-1:0][DIM-1:0][IN_W-1:0] op_b;
  logic running;
  int   lat_cnt;

  always @(posedge clk) begin
    if (adder_rst) begin
      add_done <= 1'b0;
      running  <= 1'b0;
      lat_cnt  <= 0;
      mat_c    <= '0;
    end else if (add_start) begin
      running <= 1'b1;
      lat_cnt <= 1;
      op_a    <= mat_a;
      op_b    <= mat_b;
    end else if (running) begin
      if (lat_cnt == ADD_LAT - 1) begin
        running  <= 1'b0;
        add_done <= 1'b1;
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++)
            mat_c[i][j] <= OUT_W'(op_a[i][j]) + OUT_W'(op_b[i][j]);
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  int start_cnt = 0;
  always @(negedge clk) if (add_start === 1'b1) start_cnt++;

  logic [IN_W-1:0]  job_a [N];
  logic [IN_W-1:0]  job_b [N];
  logic [OUT_W-1:0] got [N];
  logic             got_last [N];
  int   n_hs;
  int   stall_bad;
  bit   send_timeout;
  bit   drain_timeout;
  logic start_after;
  int   total = 0;
  int   bad   = 0;

  // All drivers below start and end #1 after a rising edge.
  task automatic send_job(input bit bubbles);
    int idx = 0;
    int cyc = 0;
    bit hs;
    send_timeout = 1'b0;
    while (idx < 2 * N) begin
      if (cyc > 400) begin
        send_timeout = 1'b1;
        break;
      end
      bus.in_valid = !bubbles || (cyc % 2 == 0);
      bus.in_data  = (idx < N) ? job_a[idx] : job_b[idx-N];
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    start_after  = add_start;
  endtask

  task automatic drain(input int max_hs, input bit stall_pat);
    int cyc = 0;
    bit hs;
    bit stalled = 1'b0;
    logic [OUT_W-1:0] held_d = '0;
    logic held_l = 1'b0;
    n_hs = 0;
    stall_bad = 0;
    drain_timeout = 1'b0;
    while (n_hs < max_hs) begin
      if (cyc > 400) begin
        drain_timeout = 1'b1;
        break;
      end
      bus.out_ready = stall_pat ? ((cyc % 5 == 1) || (cyc % 5 == 4)) : 1'b1;
      if (stalled && (bus.out_data !== held_d || bus.out_last !== held_l)) stall_bad++;
      hs = (bus.out_valid === 1'b1) && bus.out_ready;
      if (hs) begin
        got[n_hs]      = bus.out_data;
        got_last[n_hs] = bus.out_last;
      end
      stalled = (bus.out_valid === 1'b1) && !bus.out_ready;
      held_d  = bus.out_data;
      held_l  = bus.out_last;
      @(posedge clk); #1;
      if (hs) n_hs++;
      cyc++;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic adder_reset();
    adder_rst = 1'b1;
    @(posedge clk); #1;
    adder_rst = 1'b0;
  endtask

  task automatic load_basic();
    for (int i = 0; i < N; i++) begin
      job_a[i] = IN_W'(i);
      job_b[i] = 8'd255;
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) begin
      job_a[i] = IN_W'(16 * i);
      job_b[i] = IN_W'(i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adder_rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_last: got %b expected 0", bus.out_last); end
    total++; if (bus.out_data !== 16'd0) begin bad++; $display("[TB] FAIL rst_out_data: got %h expected 0", bus.out_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    total++; if (add_start !== 1'b0) begin bad++; $display("[TB] FAIL rst_add_start: got %b expected 0", add_start); end
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_in_ready_2: got %b expected 0", bus.in_ready); end
    rst = 1'b0;
    adder_rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_in_ready: got %b expected 1", bus.in_ready); end
    total++; if (mat_a !== '0) begin bad++; $display("[TB] FAIL rst_mat_a: got %h expected 0", mat_a); end
    total++; if (mat_b !== '0) begin bad++; $display("[TB] FAIL rst_mat_b: got %h expected 0", mat_b); end
  endtask

  task automatic test_basic();
    int s0;
    load_basic();
    s0 = start_cnt;
    send_job(1'b0);
    total++; if (send_timeout) begin bad++; $display("[TB] FAIL basic_load_timeout: got timeout expected 32 bytes"); end
    total++; if (start_after !== 1'b1) begin bad++; $display("[TB] FAIL basic_start_latency: got %b expected 1", start_after); end
    total++; if (mat_a[1][2] !== 8'd6) begin bad++; $display("[TB] FAIL basic_a12: got %0d expected 6", mat_a[1][2]); end
    total++; if (mat_a[3][3] !== 8'd15) begin bad++; $display("[TB] FAIL basic_a33: got %0d expected 15", mat_a[3][3]); end
    total++; if (mat_b[3][3] !== 8'd255) begin bad++; $display("[TB] FAIL basic_b33: got %0d expected 255", mat_b[3][3]); end
    drain(N, 1'b0);
    total++; if (drain_timeout) begin bad++; $display("[TB] FAIL basic_drain_timeout: got %0d words expected 16", n_hs); end
    for (int i = 0; i < N; i++) begin
      total++; if (got[i] !== OUT_W'(255 + i)) begin bad++; $display("[TB] FAIL basic_data[%0d]: got %0d expected %0d", i, got[i], 255 + i); end
      total++; if (got_last[i] !== (i == N - 1)) begin bad++; $display("[TB] FAIL basic_last[%0d]: got %b expected %b", i, got_last[i], i == N - 1); end
    end
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("[TB] FAIL basic_start_pulses: got %0d expected 1", start_cnt - s0); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_valid_after: got %b expected 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready_after: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_saturation();
    adder_reset();
    for (int i = 0; i < N; i++) begin
      job_a[i] = 8'd255;
      job_b[i] = 8'd255;
    end
    send_job(1'b0);
    drain(N, 1'b0);
    total++; if (drain_timeout) begin bad++; $display("[TB] FAIL sat_drain_timeout: got %0d words expected 16", n_hs); end
    for (int i = 0; i < N; i++) begin
      total++; if (got[i] !== 16'h01FE) begin bad++; $display("[TB] FAIL sat_data[%0d]: got %h expected 01fe", i, got[i]); end
    end
  endtask

  task automatic test_back_to_back();
    adder_reset();
    load_basic();
    send_job(1'b1);
    total++; if (start_after !== 1'b1) begin bad++; $display("[TB] FAIL bp_start_latency: got %b expected 1", start_after); end
    drain(N, 1'b1);
    total++; if (drain_timeout) begin bad++; $display("[TB] FAIL bp_drain_timeout: got %0d words expected 16", n_hs); end
    for (int i = 0; i < N; i++) begin
      total++; if (got[i] !== OUT_W'(255 + i)) begin bad++; $display("[TB] FAIL bp_data[%0d]: got %0d expected %0d", i, got[i], 255 + i); end
    end
    total++; if (got_last[N-1] !== 1'b1) begin bad++; $display("[TB] FAIL bp_last: got %b expected 1", got_last[N-1]); end
    total++; if (stall_bad !== 0) begin bad++; $display("[TB] FAIL bp_stall_stable: got %0d changes expected 0", stall_bad); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_extra_word: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_sticky_done();
    int cnt = 0;
    load_ramp();
    send_job(1'b0);
    while (bus.out_valid !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    // WAIT is entered one edge after the start cycle, completion lands DONE_WAIT edges later.
    total++; if (cnt !== DONE_WAIT + 1) begin bad++; $display("[TB] FAIL sticky_wait: got %0d expected %0d", cnt, DONE_WAIT + 1); end
    drain(N, 1'b0);
    for (int i = 0; i < N; i++) begin
      total++; if (got[i] !== OUT_W'(17 * i)) begin bad++; $display("[TB] FAIL sticky_data[%0d]: got %0d expected %0d", i, got[i], 17 * i); end
    end
  endtask

  task automatic test_reset_wait();
    adder_reset();
    load_basic();
    send_job(1'b0);
    repeat (5) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rw_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    adder_rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rw_busy: got %b expected 0", busy); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rw_out_valid: got %b expected 0", bus.out_valid); end
    total++; if (mat_a !== '0) begin bad++; $display("[TB] FAIL rw_mat_a: got %h expected 0", mat_a); end
    rst = 1'b0;
    adder_rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rw_in_ready: got %b expected 1", bus.in_ready); end
    load_ramp();
    send_job(1'b0);
    drain(N, 1'b0);
    for (int i = 0; i < N; i++) begin
      total++; if (got[i] !== OUT_W'(17 * i)) begin bad++; $display("[TB] FAIL rw_data[%0d]: got %0d expected %0d", i, got[i], 17 * i); end
    end
  endtask

  task automatic test_reset_drain();
    adder_reset();
    load_basic();
    send_job(1'b0);
    drain(7, 1'b0);
    total++; if (bus.out_data !== 16'd262) begin bad++; $display("[TB] FAIL rd_mid_data: got %0d expected 262", bus.out_data); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rd_mid_valid: got %b expected 1", bus.out_valid); end
    rst = 1'b1;
    adder_rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_out_valid: got %b expected 0", bus.out_valid); end
    total++; if (bus.out_data !== 16'd0) begin bad++; $display("[TB] FAIL rd_out_data: got %0d expected 0", bus.out_data); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("[TB] FAIL rd_out_last: got %b expected 0", bus.out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rd_busy: got %b expected 0", busy); end
    rst = 1'b0;
    adder_rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rd_in_ready: got %b expected 1", bus.in_ready); end
    load_ramp();
    send_job(1'b0);
    drain(N, 1'b0);
    total++; if (drain_timeout) begin bad++; $display("[TB] FAIL rd_drain_timeout: got %0d words expected 16", n_hs); end
    for (int i = 0; i < N; i++) begin
      total++; if (got[i] !== OUT_W'(17 * i)) begin bad++; $display("[TB] FAIL rd_data[%0d]: got %0d expected %0d", i, got[i], 17 * i); end
    end
    total++; if (got_last[N-1] !== 1'b1) begin bad++; $display("[TB] FAIL rd_last: got %b expected 1", got_last[N-1]); end
  endtask

  initial begin
    rst = 1'b1;
    adder_rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    $display("[TB] starting matrix_add_driver bench");
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_sticky_done();
    test_reset_wait();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
